output_stream_scheduler: RTL

- Sits between the convolution controller/datapath output (output_valid, output_x/y/ch, accumulator result) and the external result consumer.
- Buffers finished outputs in a FIFO and drains them over a valid/ready handshake.
- Asserts an early stall so the controller can hold its a/b handshake before the in-flight MAC pipeline overruns the buffer.
- Tracks the frame's output count and signals completion.

---
 rtl/output_stream_scheduler_if.sv | 36 +++
 rtl/output_stream_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/output_stream_scheduler_if.sv
// Result stream from the output scheduler to the external consumer.
// The scheduler is the master; the consumer owns out_ready.
interface output_stream_scheduler_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 32
);

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [COORD_WIDTH-1:0] out_x;
    logic [COORD_WIDTH-1:0] out_y;
    logic [COORD_WIDTH-1:0] out_ch;
    logic                   out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_x,
        output out_y,
        output out_ch,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_x,
        input  out_y,
        input  out_ch,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/output_stream_scheduler.sv
// Buffers datapath results, drains them to the consumer and raises an
// early stall so in-flight MACs never overrun the buffer.
module output_stream_scheduler #(
    parameter int DATA_WIDTH         = 32,
    parameter int COORD_WIDTH        = 32,
    parameter int FIFO_DEPTH         = 16,
    parameter int STALL_MARGIN       = 6,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                   clk,
    input  logic                   arst_in,
    input  logic                   start,
    output logic                   busy,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [COORD_WIDTH-1:0] in_x,
    input  logic [COORD_WIDTH-1:0] in_y,
    input  logic [COORD_WIDTH-1:0] in_ch,
    output logic                   stall,
    output logic                   done,
    output logic                   overflow_err,
    output logic                   extra_err,
    output_stream_scheduler_if.master out_if
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] TOTAL = 32'(FEATURE_MAP_WIDTH
                                      * FEATURE_MAP_HEIGHT
                                      * OUTPUT_NB_CHANNELS);
    localparam logic [31:0] TOTAL_M1   = TOTAL - 32'd1;
    localparam logic [31:0] CNT32_ONE  = 32'd1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0] OCC_ONE    = (AW+1)'(1);
    localparam logic [AW:0] OCC_FULL   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic [COORD_WIDTH-1:0] ch;
        logic                   last;
    } entry_t;

    state_t        state_q;
    state_t        state_d;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    entry_t        wr_entry;

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   occ_q;
    logic [31:0]   push_cnt_q;
    logic [31:0]   pop_cnt_q;
    logic [31:0]   free_slots;

    logic          empty;
    logic          full;
    logic          push_req;
    logic          pop;
    logic          wr_en;
    logic          last_push;
    logic          last_pop;
    logic          frame_clr;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_FULL);
    assign push_req  = (state_q == S_RUN) && in_valid;
    assign pop       = !empty && out_if.out_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en     = push_req && (!full || pop);
    assign last_push = push_req && (push_cnt_q == TOTAL_M1);
    assign last_pop  = pop && (pop_cnt_q == TOTAL_M1);
    assign frame_clr = (state_q == S_IDLE) && start;

    assign free_slots = 32'(FIFO_DEPTH) - 32'(occ_q);

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = in_data;
        wr_entry.x    = in_x;
        wr_entry.y    = in_y;
        wr_entry.ch   = in_ch;
        wr_entry.last = last_push;
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        stall   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                stall = (free_slots <= 32'(STALL_MARGIN));
                if (last_push) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy  = 1'b1;
                stall = 1'b0;
                if (last_pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else if (frame_clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
                pop_cnt_q <= pop_cnt_q + CNT32_ONE;
            end
            // dropped pushes still count so the frame total stays aligned
            if (push_req) begin
                push_cnt_q <= push_cnt_q + CNT32_ONE;
            end
            if (wr_en && !pop) begin
                occ_q <= occ_q + OCC_ONE;
            end else if (!wr_en && pop) begin
                occ_q <= occ_q - OCC_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            overflow_err <= 1'b0;
            extra_err    <= 1'b0;
        end else if (frame_clr) begin
            overflow_err <= 1'b0;
            extra_err    <= 1'b0;
        end else begin
            if (push_req && !wr_en) begin
                overflow_err <= 1'b1;
            end
            if ((state_q == S_DRAIN) && in_valid) begin
                extra_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // storage is not reset, so the head is masked until it holds real data
    assign head = empty ? '0 : mem[rd_ptr_q];

    assign out_if.out_valid = !empty;
    assign out_if.out_data  = head.data;
    assign out_if.out_x     = head.x;
    assign out_if.out_y     = head.y;
    assign out_if.out_ch    = head.ch;
    assign out_if.out_last  = head.last;

endmodule
